// File: rtl/npu_axi_pkg.sv
// rtl/npu_axi_pkg.sv - shared AXI encodings, 4 KB page constants and read-engine FSM states
package npu_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_BITS  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/axi_burst_calc.sv
// rtl/axi_burst_calc.sv - beats of the next INCR burst, capped by remaining work, max length and 4 KB page end
module axi_burst_calc
  import npu_axi_pkg::*;
#(
  parameter int LEN_WIDTH     = 8,
  parameter int CNT_WIDTH     = 20,
  parameter int MAX_BURST_LEN = 16,
  parameter int BYTES         = 16,
  localparam int OFF_LSB      = $clog2(BYTES)
) (
  input  logic [PAGE_BITS-OFF_LSB-1:0] page_off,
  input  logic [CNT_WIDTH-1:0]         issue_left,
  output logic [CNT_WIDTH-1:0]         beats,
  output logic [LEN_WIDTH-1:0]         len
);

  localparam int PAGE_BEATS = PAGE_BYTES / BYTES;

  logic [CNT_WIDTH-1:0] page_left;

  always_comb begin
    page_left = CNT_WIDTH'(PAGE_BEATS) - CNT_WIDTH'(page_off);
    beats     = issue_left;
    if (beats > CNT_WIDTH'(MAX_BURST_LEN)) beats = CNT_WIDTH'(MAX_BURST_LEN);
    if (beats > page_left) beats = page_left;
    // Idle (no work left) reports len 0 rather than wrapping to all-ones.
    len = (beats == '0) ? '0 : LEN_WIDTH'(beats - CNT_WIDTH'(1));
  end

endmodule

// File: rtl/axi4_rd_burst_engine.sv
// rtl/axi4_rd_burst_engine.sv - splits a linear read descriptor into AXI INCR bursts and streams the beats out
module axi4_rd_burst_engine
  import npu_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ADDR_WIDTH  = 40,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEAT_CNT_WIDTH  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [BEAT_CNT_WIDTH-1:0] num_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      rd_req,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  output logic [AXI_LEN_WIDTH-1:0]  rd_len,
  output logic [2:0]                rd_size,
  output logic [1:0]                rd_burst,
  input  logic                      rd_ready,
  input  logic                      rd_valid,
  input  logic [AXI_DATA_WIDTH-1:0] rd_data,
  input  logic [1:0]                rd_resp,
  input  logic                      rd_last,
  output logic                      rd_accept,
  output logic                      out_valid,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int OFF_LSB = $clog2(BYTES);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

  rd_state_e                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [BEAT_CNT_WIDTH-1:0] issue_left_q, issue_left_d;
  logic [BEAT_CNT_WIDTH-1:0] data_left_q, data_left_d;
  logic [BEAT_CNT_WIDTH-1:0] burst_beats;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  logic                      err_q, err_d, done_q, done_d;
  logic                      req_fire, beat_xfer, burst_done;

  axi_burst_calc #(
    .LEN_WIDTH    (AXI_LEN_WIDTH),
    .CNT_WIDTH    (BEAT_CNT_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .BYTES        (BYTES)
  ) u_calc (
    .page_off  (cur_addr_q[PAGE_BITS-1:OFF_LSB]),
    .issue_left(issue_left_q),
    .beats     (burst_beats),
    .len       (rd_len)
  );

  assign rd_req = (state_q == ST_ISSUE) && (issue_left_q != '0) &&
                  (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign req_fire = rd_req & rd_ready;
  // Beats outside an active transfer are swallowed without touching any counter.
  assign beat_xfer  = rd_valid & out_ready & ((state_q == ST_ISSUE) | (state_q == ST_DRAIN));
  assign burst_done = beat_xfer & rd_last;

  assign rd_addr   = cur_addr_q;
  assign rd_size   = 3'(OFF_LSB);
  assign rd_burst  = BURST_INCR;
  assign rd_accept = out_ready;
  assign out_valid = rd_valid;
  assign out_data  = rd_data;
  assign out_last  = rd_valid & (data_left_q == BEAT_CNT_WIDTH'(1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    issue_left_d  = issue_left_q;
    data_left_d   = data_left_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    done_d        = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d    = src_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
          issue_left_d  = num_beats;
          data_left_d   = num_beats;
          outstanding_d = '0;
          err_d         = 1'b0;
          state_d       = (num_beats == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        if (req_fire) begin
          cur_addr_d   = cur_addr_q + (AXI_ADDR_WIDTH'(burst_beats) << OFF_LSB);
          issue_left_d = issue_left_q - burst_beats;
        end
        outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(burst_done);
        if (beat_xfer && (data_left_q != '0)) begin
          data_left_d = data_left_q - BEAT_CNT_WIDTH'(1);
        end
        if (beat_xfer && (rd_resp != RESP_OKAY)) err_d = 1'b1;
        if ((state_q == ST_ISSUE) && (issue_left_d == '0)) state_d = ST_DRAIN;
        if ((state_q == ST_DRAIN) && (data_left_q == '0)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      issue_left_q  <= '0;
      data_left_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      issue_left_q  <= issue_left_d;
      data_left_q   <= data_left_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: doc/axi4_rd_burst_engine.md
Name: axi4_rd_burst_engine

Overview:
- Read-side DMA front end that sits directly upstream of the AXI4 master's user read interface.
- Accepts one linear read descriptor (start address, beat count) and splits it into AXI INCR bursts that never exceed MAX_BURST_LEN beats and never cross a 4 KB boundary.
- Drives rd_req/rd_addr/rd_len/rd_size/rd_burst to the master and limits in-flight bursts.
- Forwards returned beats as a valid/ready stream with an end-of-transfer marker, and reports done plus a sticky error.

Parameters:
- AXI_DATA_WIDTH, 128, data bus width in bits; BYTES = AXI_DATA_WIDTH/8.
- AXI_ADDR_WIDTH, 40, address width.
- AXI_LEN_WIDTH, 8, AXI burst length field width.
- MAX_BURST_LEN, 16, maximum beats per burst (1..2^AXI_LEN_WIDTH).
- MAX_OUTSTANDING, 4, maximum bursts issued but not fully returned.
- BEAT_CNT_WIDTH, 20, width of the descriptor beat count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  descriptor strobe; sampled only when busy=0
- src_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(BYTES) bits forced to 0
- num_beats  in  BEAT_CNT_WIDTH  total beats to read; 0 is legal
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the transfer completes
- err  out  1  sticky error for the last transfer; cleared on accepted start
- rd_req  out  1  burst request to the master
- rd_addr  out  AXI_ADDR_WIDTH  burst start address
- rd_len  out  AXI_LEN_WIDTH  beats-1
- rd_size  out  3  constant log2(BYTES)
- rd_burst  out  2  constant INCR (2'b01)
- rd_ready  in  1  master can accept a request
- rd_valid  in  1  read beat valid
- rd_data  in  AXI_DATA_WIDTH  read beat data
- rd_resp  in  2  read beat response
- rd_last  in  1  last beat of the burst
- rd_accept  out  1  beat accepted; equals out_ready
- out_valid  out  1  stream beat valid; equals rd_valid
- out_data  out  AXI_DATA_WIDTH  stream data; equals rd_data
- out_last  out  1  final beat of the whole transfer
- out_ready  in  1  downstream ready

Behaviour:
- Reset: busy=0, done=0, err=0, rd_req=0, rd_addr=0, rd_len=0. All counters are cleared. FSM goes to IDLE.
- Reset mid-transfer aborts locally and drops outstanding tracking. The master must be reset in the same cycle.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches the address and beat count, clears err, and sets busy=1 next cycle.
  - If num_beats=0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - rd_req=1 when issue_left>0 and outstanding<MAX_OUTSTANDING.
  - A request is accepted when rd_req & rd_ready in the same cycle.
  - On accept: cur_addr += beats*BYTES, issue_left -= beats, outstanding += 1. rd_addr/rd_len for the next burst update the following cycle.
  - rd_req stays high while conditions hold. At most one request is accepted per cycle.
- Burst size: beats = min(issue_left, MAX_BURST_LEN, 4096/BYTES - cur_addr[11:log2(BYTES)]). rd_len = beats-1.
- When issue_left reaches 0, go to DRAIN.
- Data path is pass-through with zero latency. A beat transfers on rd_valid & out_ready.
  - Each transferred beat decrements data_left.
  - outstanding decrements on a transferred beat with rd_last=1.
  - The same-cycle accept and rd_last completion leave outstanding unchanged.
- out_last = out_valid & (data_left==1).
- err |= (rd_resp != 2'b00) on every transferred beat. All beats are still consumed.
- DRAIN: when data_left reaches 0, go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE. err holds until the next accepted start.
- start while busy=1 is ignored.
- Beats arriving in IDLE are unexpected: rd_accept still follows out_ready and no counters change.

Decomposition:
- Package npu_axi_pkg holds:
  - BURST_FIXED/INCR/WRAP
  - RESP_OKAY/EXOKAY/SLVERR/DECERR
  - the 4 KB page constant
  - the FSM state typedef
- Sub-module axi_burst_calc: combinational beats/rd_len computation from cur_addr, issue_left, MAX_BURST_LEN and BYTES.

Test Plan:
- src_addr=0x0, num_beats=40, ready sink -> 3 requests: addr 0x000 len 15, 0x100 len 15, 0x200 len 7. 40 beats out, out_last on beat 40, done pulses once, err=0.
- src_addr=0xF80, num_beats=20 -> requests 0xF80 len 7 and 0x1000 len 11. No burst crosses 0x1000.
- src_addr=0x0, num_beats=100, rd_ready=1, out_ready=0, no data returned -> exactly 4 requests issued, then rd_req=0 until one burst completes.
- num_beats=24, SLVERR on beat 3 -> all 24 beats still drained, err=1 at done, err cleared on the next start.
- num_beats=0 -> no rd_req, done pulses 2 cycles after start, busy high for 1 cycle.
- start pulsed while busy, then rst asserted mid-burst -> second start ignored. After rst: busy=0, rd_req=0, outstanding=0, and a new transfer completes correctly.
